// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Far end of a 4-row x 3-column matrix keypad scan interface. Accepts one key
//   code over a valid/ready handshake and plays out a full key press (press
//   bounce, hold, release bounce, inter-key gap). While the emulated contact
//   is closed, the key's column line follows its row strobe one cycle late.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   key_valid/key_code  key request: 0-9 digits, 10 = *, 11 = #, 12-15 illegal
//   key_ready           idle, a request on this edge will be accepted
//   busy                press sequence in progress
//   done                one-cycle pulse in the first idle cycle after a sequence
//   err                 one-cycle pulse after an illegal-code handshake
//   B, G, F, D          row strobes from the scanner, active-high
//   C, A, E             column returns, active-high, registered
//
// Key map (row: C A E):  B: 1 2 3   G: 4 5 6   F: 7 8 9   D: * 0 #
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYC     = 1000,
  parameter int unsigned BOUNCE_TOGGLES = 4,
  parameter int unsigned HOLD_CYC       = 2000000,
  parameter int unsigned GAP_CYC        = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       B,
  input  logic       G,
  input  logic       F,
  input  logic       D,
  output logic       C,
  output logic       A,
  output logic       E
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_BNC = 3'd1,
    HOLD      = 3'd2,
    REL_BNC   = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Terminal counts; every phase counter runs 0 .. LAST and then wraps.
  localparam logic [31:0] BNC_LAST  = 32'(BOUNCE_CYC - 1);
  localparam logic [31:0] SEG_LAST  = 32'(2 * BOUNCE_TOGGLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;       // cycles within current segment/phase
  logic [31:0] seg_q, seg_d;       // bounce segment index
  logic [3:0]  row_sel_q, row_sel_d; // one-hot {D,F,G,B} of latched key
  logic [2:0]  col_sel_q, col_sel_d; // one-hot {E,A,C} of latched key
  logic [2:0]  col_q, col_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        contact;
  logic [3:0]  rows;

  assign rows = {D, F, G, B};

  // Legal key code -> {row one-hot, column one-hot}
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] r;
    case (code)
      4'd1:    r = {4'b0001, 3'b001};
      4'd2:    r = {4'b0001, 3'b010};
      4'd3:    r = {4'b0001, 3'b100};
      4'd4:    r = {4'b0010, 3'b001};
      4'd5:    r = {4'b0010, 3'b010};
      4'd6:    r = {4'b0010, 3'b100};
      4'd7:    r = {4'b0100, 3'b001};
      4'd8:    r = {4'b0100, 3'b010};
      4'd9:    r = {4'b0100, 3'b100};
      4'd10:   r = {4'b1000, 3'b001};
      4'd0:    r = {4'b1000, 3'b010};
      4'd11:   r = {4'b1000, 3'b100};
      default: r = 7'b0;
    endcase
    return r;
  endfunction

  // Contact state: press bounce starts closed on even segments, release
  // bounce starts open, so the two phases are mirror images on seg_q[0].
  always_comb begin
    contact = 1'b0;
    case (state_q)
      PRESS_BNC: contact = ~seg_q[0];
      HOLD:      contact = 1'b1;
      REL_BNC:   contact = seg_q[0];
      default:   contact = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    row_sel_d = row_sel_q;
    col_sel_d = col_sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_code < 4'd12) begin
            state_d                = PRESS_BNC;
            cnt_d                  = '0;
            seg_d                  = '0;
            {row_sel_d, col_sel_d} = decode(key_code);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRESS_BNC, REL_BNC: begin
        if (cnt_q == BNC_LAST) begin
          cnt_d = '0;
          if (seg_q == SEG_LAST) begin
            seg_d   = '0;
            state_d = (state_q == PRESS_BNC) ? HOLD : GAP;
          end else begin
            seg_d = seg_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = REL_BNC;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        seg_d   = '0;
      end
    endcase
  end

  // Multiple rows high is fine: only the key's own row matters.
  always_comb begin
    col_d = 3'b000;
    if (contact && |(rows & row_sel_q)) col_d = col_sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seg_q     <= '0;
      row_sel_q <= '0;
      col_sel_q <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      row_sel_q <= row_sel_d;
      col_sel_q <= col_sel_d;
      col_q     <= col_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign {E, A, C} = col_q;

endmodule
